// File: rtl/inference_loader_ctrl_if.sv
// rtl/inference_loader_ctrl_if.sv - host byte stream, memory write, engine and result signals of the loader
interface inference_loader_ctrl_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata8;
    logic [31:0] mem_wdata32;
    logic        img_we;
    logic        conv_w_we;
    logic        conv_b_we;
    logic        dense_w_we;
    logic        dense_b_we;
    logic        inf_rst;
    logic        inf_start;
    logic        inf_done;
    logic [3:0]  inf_digit;
    logic [3:0]  res_digit;
    logic        res_valid;
    logic        res_ready;
    logic        bad_hdr;
    logic        busy;

    modport master (
        input  in_data, in_valid, inf_done, inf_digit, res_ready,
        output in_ready, mem_addr, mem_wdata8, mem_wdata32,
               img_we, conv_w_we, conv_b_we, dense_w_we, dense_b_we,
               inf_rst, inf_start, res_digit, res_valid, bad_hdr, busy
    );

    modport slave (
        output in_data, in_valid, inf_done, inf_digit, res_ready,
        input  in_ready, mem_addr, mem_wdata8, mem_wdata32,
               img_we, conv_w_we, conv_b_we, dense_w_we, dense_b_we,
               inf_rst, inf_start, res_digit, res_valid, bad_hdr, busy
    );
endinterface

// File: rtl/inference_loader_ctrl.sv
// rtl/inference_loader_ctrl.sv - framed byte loader into engine memories plus engine run sequencer
module inference_loader_ctrl #(
    parameter int IMG_BYTES     = 784,
    parameter int CONV_W_BYTES  = 36,
    parameter int CONV_B_WORDS  = 4,
    parameter int DENSE_W_BYTES = 27040,
    parameter int DENSE_B_WORDS = 10
) (
    input  logic clk,
    input  logic rst,
    inference_loader_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PAYLOAD, S_FLUSH, S_RUN_RST, S_RUN_GO, S_RUN_WAIT, S_RESULT
    } state_t;

    typedef enum logic [2:0] {
        T_CONV_W, T_CONV_B, T_DENSE_W, T_DENSE_B, T_IMG
    } tgt_t;

    state_t      state_q, state_d;
    tgt_t        tgt_q, tgt_d;
    logic [14:0] cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  wdata8_q, wdata8_d;
    logic [31:0] wdata32_q, wdata32_d;
    logic        img_we_q, img_we_d;
    logic        conv_w_we_q, conv_w_we_d;
    logic        conv_b_we_q, conv_b_we_d;
    logic        dense_w_we_q, dense_w_we_d;
    logic        dense_b_we_q, dense_b_we_d;
    logic        bad_hdr_q, bad_hdr_d;
    logic [3:0]  res_digit_q, res_digit_d;

    logic        in_ready;
    logic        accept;
    logic        word_tgt;
    logic [14:0] last_idx;
    logic [31:0] shifted;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_PAYLOAD);
    assign accept   = bus.in_valid && in_ready;
    assign word_tgt = (tgt_q == T_CONV_B) || (tgt_q == T_DENSE_B);
    // Little-endian assembly: the newest byte enters at the top.
    assign shifted  = {bus.in_data, shift_q[31:8]};

    always_comb begin
        last_idx = 15'(IMG_BYTES - 1);
        case (tgt_q)
            T_CONV_W:  last_idx = 15'(CONV_W_BYTES - 1);
            T_CONV_B:  last_idx = 15'(CONV_B_WORDS * 4 - 1);
            T_DENSE_W: last_idx = 15'(DENSE_W_BYTES - 1);
            T_DENSE_B: last_idx = 15'(DENSE_B_WORDS * 4 - 1);
            default:   last_idx = 15'(IMG_BYTES - 1);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        addr_d       = addr_q;
        wdata8_d     = wdata8_q;
        wdata32_d    = wdata32_q;
        img_we_d     = 1'b0;
        conv_w_we_d  = 1'b0;
        conv_b_we_d  = 1'b0;
        dense_w_we_d = 1'b0;
        dense_b_we_d = 1'b0;
        bad_hdr_d    = 1'b0;
        res_digit_d  = res_digit_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    case (bus.in_data)
                        8'h01: begin tgt_d = T_CONV_W;  state_d = S_PAYLOAD; end
                        8'h02: begin tgt_d = T_CONV_B;  state_d = S_PAYLOAD; end
                        8'h03: begin tgt_d = T_DENSE_W; state_d = S_PAYLOAD; end
                        8'h04: begin tgt_d = T_DENSE_B; state_d = S_PAYLOAD; end
                        8'h05: begin tgt_d = T_IMG;     state_d = S_PAYLOAD; end
                        8'h06: state_d = S_RUN_RST;
                        default: bad_hdr_d = 1'b1;
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 15'd1;
                    if (word_tgt) begin
                        shift_d = shifted;
                        if (cnt_q[1:0] == 2'd3) begin
                            wdata32_d    = shifted;
                            addr_d       = {2'b00, cnt_q[14:2]};
                            conv_b_we_d  = (tgt_q == T_CONV_B);
                            dense_b_we_d = (tgt_q == T_DENSE_B);
                        end
                    end else begin
                        addr_d       = cnt_q;
                        wdata8_d     = bus.in_data;
                        conv_w_we_d  = (tgt_q == T_CONV_W);
                        dense_w_we_d = (tgt_q == T_DENSE_W);
                        img_we_d     = (tgt_q == T_IMG);
                    end
                    if (cnt_q == last_idx)
                        state_d = (tgt_q == T_IMG) ? S_FLUSH : S_IDLE;
                end
            end
            // One stall cycle so the final image write lands before the engine reset.
            S_FLUSH:   state_d = S_RUN_RST;
            S_RUN_RST: state_d = S_RUN_GO;
            S_RUN_GO:  state_d = S_RUN_WAIT;
            S_RUN_WAIT: begin
                if (bus.inf_done) begin
                    res_digit_d = bus.inf_digit;
                    state_d     = S_RESULT;
                end
            end
            S_RESULT: begin
                if (bus.res_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tgt_q        <= T_CONV_W;
            cnt_q        <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            wdata8_q     <= '0;
            wdata32_q    <= '0;
            img_we_q     <= 1'b0;
            conv_w_we_q  <= 1'b0;
            conv_b_we_q  <= 1'b0;
            dense_w_we_q <= 1'b0;
            dense_b_we_q <= 1'b0;
            bad_hdr_q    <= 1'b0;
            res_digit_q  <= '0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            wdata8_q     <= wdata8_d;
            wdata32_q    <= wdata32_d;
            img_we_q     <= img_we_d;
            conv_w_we_q  <= conv_w_we_d;
            conv_b_we_q  <= conv_b_we_d;
            dense_w_we_q <= dense_w_we_d;
            dense_b_we_q <= dense_b_we_d;
            bad_hdr_q    <= bad_hdr_d;
            res_digit_q  <= res_digit_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata8  = wdata8_q;
    assign bus.mem_wdata32 = wdata32_q;
    assign bus.img_we      = img_we_q;
    assign bus.conv_w_we   = conv_w_we_q;
    assign bus.conv_b_we   = conv_b_we_q;
    assign bus.dense_w_we  = dense_w_we_q;
    assign bus.dense_b_we  = dense_b_we_q;
    assign bus.inf_rst     = (state_q == S_RUN_RST);
    assign bus.inf_start   = (state_q == S_RUN_GO);
    assign bus.res_digit   = res_digit_q;
    assign bus.res_valid   = (state_q == S_RESULT);
    assign bus.bad_hdr     = bad_hdr_q;
    assign bus.busy        = (state_q != S_IDLE);
endmodule
